// File: rtl/msx_joy_router_pkg.sv
// -----------------------------------------------------------------------------
// msx_joy_pkg
// Shared constants, types and helpers for the MSX joystick router.
//   JOY_W / PIN_W        : host joystick word width / MSX pins per port
//   JB_*                 : bit positions inside a host joystick word
//   PIN_*                : bit positions inside one MSX port's pin group
//   dir_t / socd_clean() : direction bundle and opposite-direction cleaner
// -----------------------------------------------------------------------------
package msx_joy_pkg;

  localparam int JOY_W = 16;
  localparam int PIN_W = 6;

  // Host joystick word layout (bits [15:8] carry nothing we use)
  localparam int JB_RIGHT  = 0;
  localparam int JB_LEFT   = 1;
  localparam int JB_DOWN   = 2;
  localparam int JB_UP     = 3;
  localparam int JB_TRIG_A = 4;
  localparam int JB_TRIG_B = 5;
  localparam int JB_AF_A   = 6;
  localparam int JB_AF_B   = 7;

  // MSX port pin group layout, [5:0] = p9,p6,right,left,down,up
  localparam int PIN_UP    = 0;
  localparam int PIN_DOWN  = 1;
  localparam int PIN_LEFT  = 2;
  localparam int PIN_RIGHT = 3;
  localparam int PIN_P6    = 4;
  localparam int PIN_P9    = 5;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
  } dir_t;

  // Opposite directions pressed together cancel out, so the core never
  // sees a physically impossible stick position.
  function automatic dir_t socd_clean(input dir_t d);
    dir_t c;
    c = d;
    if (d.up && d.down) begin
      c.up   = 1'b0;
      c.down = 1'b0;
    end
    if (d.left && d.right) begin
      c.left  = 1'b0;
      c.right = 1'b0;
    end
    return c;
  endfunction

endpackage

// File: rtl/msx_joy_router_if.sv
// -----------------------------------------------------------------------------
// msx_joy_router_if
// Bus between the host IO controller side and the joystick router.
//   joy_src_i     : NUM_SRC host joystick words, source s at [16s+15:16s]
//   map_sel_i     : requested source selector per port
//   map_load_i    : one-cycle pulse capturing map_sel_i as the pending map
//   vsync_n_i     : core vertical sync, active low
//   joy_pins_n_o  : per-port active-low pins {p9,p6,right,left,down,up}
//   map_cur_o     : map currently applied
//   map_pending_o : a loaded map waits for the next vsync edge
// Modports: master drives the requests, slave is the router.
// -----------------------------------------------------------------------------
interface msx_joy_router_if
  import msx_joy_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int NUM_SRC   = 4,
  parameter int SEL_W     = 3
);

  logic [NUM_SRC*JOY_W-1:0]   joy_src_i;
  logic [NUM_PORTS*SEL_W-1:0] map_sel_i;
  logic                       map_load_i;
  logic                       vsync_n_i;
  logic [NUM_PORTS*PIN_W-1:0] joy_pins_n_o;
  logic [NUM_PORTS*SEL_W-1:0] map_cur_o;
  logic                       map_pending_o;

  modport master (
    output joy_src_i, map_sel_i, map_load_i, vsync_n_i,
    input  joy_pins_n_o, map_cur_o, map_pending_o
  );

  modport slave (
    input  joy_src_i, map_sel_i, map_load_i, vsync_n_i,
    output joy_pins_n_o, map_cur_o, map_pending_o
  );

endinterface

// File: rtl/msx_joy_router_af_prescaler.sv
// -----------------------------------------------------------------------------
// msx_joy_af_prescaler
// Free-running autofire phase generator shared by all ports. A counter runs
// 0..CLK_HZ/(2*AF_HZ)-1 and the phase flips on every wrap, giving one full
// on/off period per 1/AF_HZ. Only instantiated when MSX_JOY_AUTOFIRE_EN is set.
//   clk_sys    : system clock
//   reset_n    : synchronous active-low reset (counter and phase to 0)
//   af_phase_o : current autofire phase
// -----------------------------------------------------------------------------
module msx_joy_af_prescaler #(
  parameter int CLK_HZ = 21477000,
  parameter int AF_HZ  = 10
) (
  input  logic clk_sys,
  input  logic reset_n,
  output logic af_phase_o
);

  // Degenerate rates collapse to toggling every cycle instead of breaking
  localparam int HALF_RAW = CLK_HZ / (2 * AF_HZ);
  localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int CNT_W    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             wrap;

  // Next-state: wrap the counter and flip the phase together
  always_comb begin
    wrap    = (cnt_q == CNT_LAST);
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    phase_d = wrap ? ~phase_q : phase_q;
  end

  // State registers
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign af_phase_o = phase_q;

endmodule

// File: rtl/msx_joy_router.sv
// -----------------------------------------------------------------------------
// msx_joy_router
// Routes host joystick words onto the MSX core's active-low joystick pins.
// Each port picks a source through a map that only changes on a vsync
// falling edge, so a swap never lands mid-frame. Opposite directions are
// cleaned per port after selection. Optional autofire is enabled with the
// MSX_JOY_AUTOFIRE_EN macro.
//   clk_sys  : system clock
//   reset_n  : synchronous active-low reset
//   bus      : msx_joy_router_if.slave (sources, map control, vsync, pins)
// Latency: input word change to pin change is exactly two cycles.
// -----------------------------------------------------------------------------
module msx_joy_router
  import msx_joy_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int NUM_SRC   = 4,
  parameter int SEL_W     = 3,
  parameter int CLK_HZ    = 21477000,
  parameter int AF_HZ     = 10
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  msx_joy_router_if.slave      bus
);

`ifdef MSX_JOY_AUTOFIRE_EN
  localparam int USE_W = 8;
`else
  localparam int USE_W = 6;
`endif

  // Ports beyond the number of sources start idle (selector == NUM_SRC)
  function automatic logic [NUM_PORTS*SEL_W-1:0] identity_map();
    logic [NUM_PORTS*SEL_W-1:0] m;
    m = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      m[p*SEL_W +: SEL_W] = (p < NUM_SRC) ? SEL_W'(p) : SEL_W'(NUM_SRC);
    end
    return m;
  endfunction

  localparam logic [NUM_PORTS*SEL_W-1:0] IDENT_MAP = identity_map();

  logic [NUM_SRC*JOY_W-1:0]   src_q;
  logic [NUM_PORTS*SEL_W-1:0] map_cur_q, map_cur_d;
  logic [NUM_PORTS*SEL_W-1:0] pend_map_q, pend_map_d;
  logic                       pend_q, pend_d;
  logic                       vsync_prev_q;
  logic                       vsync_fall;
  logic [NUM_PORTS*PIN_W-1:0] pins_q, pins_d;

  logic [SEL_W-1:0]           sel;
  logic [USE_W-1:0]           word;
  logic                       hit;
  dir_t                       dir_raw;
  dir_t                       dir_cln;
  logic [PIN_W-1:0]           pressed;

  // Bits of each host word that no pin ever looks at
  logic [NUM_SRC-1:0]         unused_src_bits;
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_unused
    assign unused_src_bits[s] = ^src_q[s*JOY_W+USE_W +: JOY_W-USE_W];
  end

`ifdef MSX_JOY_AUTOFIRE_EN
  logic af_phase;

  msx_joy_af_prescaler #(
    .CLK_HZ (CLK_HZ),
    .AF_HZ  (AF_HZ)
  ) u_af_prescaler (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .af_phase_o (af_phase)
  );
`else
  localparam int unused_af_params = CLK_HZ + AF_HZ;
`endif

  // A falling vsync is seen one cycle after it arrives via the registered
  // previous value. A load in that same cycle takes priority: it refreshes
  // the pending map and leaves the current map alone until the next edge.
  always_comb begin
    vsync_fall = vsync_prev_q & ~bus.vsync_n_i;
    map_cur_d  = map_cur_q;
    pend_map_d = pend_map_q;
    pend_d     = pend_q;
    if (bus.map_load_i) begin
      pend_map_d = bus.map_sel_i;
      pend_d     = 1'b1;
    end else if (vsync_fall && pend_q) begin
      map_cur_d = pend_map_q;
      pend_d    = 1'b0;
    end
  end

  // Per-port pin computation from the registered sources. Out-of-range
  // selectors never match a source and leave the port idle (all ones).
  always_comb begin
    pins_d  = '1;
    sel     = '0;
    word    = '0;
    hit     = 1'b0;
    dir_raw = '0;
    dir_cln = '0;
    pressed = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      sel  = map_cur_q[p*SEL_W +: SEL_W];
      word = '0;
      hit  = 1'b0;
      for (int s = 0; s < NUM_SRC; s++) begin
        if (sel == SEL_W'(s)) begin
          word = src_q[s*JOY_W +: USE_W];
          hit  = 1'b1;
        end
      end
      dir_raw.up    = word[JB_UP];
      dir_raw.down  = word[JB_DOWN];
      dir_raw.left  = word[JB_LEFT];
      dir_raw.right = word[JB_RIGHT];
      dir_cln       = socd_clean(dir_raw);
      pressed            = '0;
      pressed[PIN_UP]    = dir_cln.up;
      pressed[PIN_DOWN]  = dir_cln.down;
      pressed[PIN_LEFT]  = dir_cln.left;
      pressed[PIN_RIGHT] = dir_cln.right;
`ifdef MSX_JOY_AUTOFIRE_EN
      pressed[PIN_P6]    = word[JB_TRIG_A] | (word[JB_AF_A] & af_phase);
      pressed[PIN_P9]    = word[JB_TRIG_B] | (word[JB_AF_B] & af_phase);
`else
      pressed[PIN_P6]    = word[JB_TRIG_A];
      pressed[PIN_P9]    = word[JB_TRIG_B];
`endif
      if (hit) begin
        pins_d[p*PIN_W +: PIN_W] = ~pressed;
      end
    end
  end

  // Two-stage pipeline plus map state; vsync_prev starts high so leaving
  // reset with vsync low does not look like an edge.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      src_q        <= '0;
      pins_q       <= '1;
      map_cur_q    <= IDENT_MAP;
      pend_map_q   <= '0;
      pend_q       <= 1'b0;
      vsync_prev_q <= 1'b1;
    end else begin
      src_q        <= bus.joy_src_i;
      pins_q       <= pins_d;
      map_cur_q    <= map_cur_d;
      pend_map_q   <= pend_map_d;
      pend_q       <= pend_d;
      vsync_prev_q <= bus.vsync_n_i;
    end
  end

  assign bus.joy_pins_n_o  = pins_q;
  assign bus.map_cur_o     = map_cur_q;
  assign bus.map_pending_o = pend_q;

endmodule

// File: tb/tb_msx_joy_router.sv
// -----------------------------------------------------------------------------
// tb_msx_joy_router
// Directed bench for msx_joy_router with NUM_PORTS=2, NUM_SRC=4, SEL_W=3,
// CLK_HZ=1000, AF_HZ=10. Honours MSX_JOY_AUTOFIRE_EN the same way the design
// does, so it can be built with or without autofire.
// -----------------------------------------------------------------------------
module tb_msx_joy_router;
  import msx_joy_pkg::*;

  localparam int NP = 2;
  localparam int NS = 4;
  localparam int SW = 3;

  logic clk_sys;
  logic reset_n;
  int   checks;
  int   failures;

  msx_joy_router_if #(.NUM_PORTS(NP), .NUM_SRC(NS), .SEL_W(SW)) bus ();

  msx_joy_router #(
    .NUM_PORTS (NP),
    .NUM_SRC   (NS),
    .SEL_W     (SW),
    .CLK_HZ    (1000),
    .AF_HZ     (10)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // 100 MHz-style clock, 10 time units per period
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Advance n rising edges and settle 1 unit after the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // Drive every request input of the router at once
  task automatic applyStimulus(input logic [63:0] src, input logic [5:0] sel,
                               input logic load, input logic vsyncN);
    bus.joy_src_i  = src;
    bus.map_sel_i  = sel;
    bus.map_load_i = load;
    bus.vsync_n_i  = vsyncN;
  endtask

  // One comparison: count it, and on mismatch count and report it
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [63:0] src;
    int          lowCount;
    int          lastChange;
    int          changes;
    logic        prevP6;

    checks   = 0;
    failures = 0;
    lowCount = 0;
    lastChange = -1;
    changes  = 0;

    // Reset state
    reset_n = 1'b0;
    applyStimulus(64'h0, 6'h0, 1'b0, 1'b1);
    tick(3);
    checkOutput("reset_pins", 64'(bus.joy_pins_n_o), 64'hFFF);
    checkOutput("reset_map", 64'(bus.map_cur_o), 64'(6'b001_000));
    checkOutput("reset_pending", 64'(bus.map_pending_o), 64'h0);
    reset_n = 1'b1;
    tick(2);
    checkOutput("idle_pins", 64'(bus.joy_pins_n_o), 64'hFFF);

    // Up on source 0: exactly two cycles to reach port 0 pin 0
    applyStimulus(64'h0008, 6'b001_000, 1'b0, 1'b1);
    tick(1);
    checkOutput("latency_one_cycle", 64'(bus.joy_pins_n_o), 64'hFFF);
    tick(1);
    checkOutput("up_port0", 64'(bus.joy_pins_n_o), 64'hFFE);

    // Opposite directions cancel
    applyStimulus(64'h000C, 6'b001_000, 1'b0, 1'b1);
    tick(2);
    checkOutput("socd_up_down", 64'(bus.joy_pins_n_o), 64'hFFF);
    applyStimulus(64'h0003, 6'b001_000, 1'b0, 1'b1);
    tick(2);
    checkOutput("socd_left_right", 64'(bus.joy_pins_n_o), 64'hFFF);

    // Right on src0, trigger A on src1
    src = 64'h0000_0000_0010_0001;
    applyStimulus(src, 6'b001_000, 1'b0, 1'b1);
    tick(2);
    checkOutput("two_ports", 64'(bus.joy_pins_n_o), 64'hBF7);

    // Mid-frame load: pending, nothing moves until vsync
    applyStimulus(src, 6'b000_001, 1'b1, 1'b1);
    tick(1);
    applyStimulus(src, 6'b000_001, 1'b0, 1'b1);
    checkOutput("load_pending", 64'(bus.map_pending_o), 64'h1);
    checkOutput("load_map_held", 64'(bus.map_cur_o), 64'(6'b001_000));
    tick(2);
    checkOutput("load_pins_held", 64'(bus.joy_pins_n_o), 64'hBF7);

    // Vsync falls: commit on the detection edge, pins follow one cycle later
    applyStimulus(src, 6'b000_001, 1'b0, 1'b0);
    tick(1);
    checkOutput("commit_map", 64'(bus.map_cur_o), 64'(6'b000_001));
    checkOutput("commit_pending", 64'(bus.map_pending_o), 64'h0);
    applyStimulus(src, 6'b000_001, 1'b0, 1'b1);
    tick(1);
    checkOutput("swapped_pins", 64'(bus.joy_pins_n_o), 64'hDEF);
    tick(2);

    // Load coinciding with edge detection wins; commit at the next edge
    applyStimulus(src, 6'b001_000, 1'b1, 1'b0);
    tick(1);
    applyStimulus(src, 6'b001_000, 1'b0, 1'b0);
    checkOutput("coincide_map_kept", 64'(bus.map_cur_o), 64'(6'b000_001));
    checkOutput("coincide_pending", 64'(bus.map_pending_o), 64'h1);
    tick(2);
    applyStimulus(src, 6'b001_000, 1'b0, 1'b1);
    tick(2);
    checkOutput("coincide_still_old", 64'(bus.map_cur_o), 64'(6'b000_001));
    applyStimulus(src, 6'b001_000, 1'b0, 1'b0);
    tick(1);
    checkOutput("coincide_next_edge", 64'(bus.map_cur_o), 64'(6'b001_000));
    checkOutput("coincide_cleared", 64'(bus.map_pending_o), 64'h0);
    applyStimulus(src, 6'b001_000, 1'b0, 1'b1);
    tick(1);
    checkOutput("coincide_pins", 64'(bus.joy_pins_n_o), 64'hBF7);

    // Overwrite pending with {port1=2, port0=5}; selector 5 is out of range
    src = 64'h0000_0024_0010_0001;
    applyStimulus(src, 6'b001_001, 1'b1, 1'b1);
    tick(1);
    applyStimulus(src, 6'b010_101, 1'b1, 1'b1);
    tick(1);
    applyStimulus(src, 6'b010_101, 1'b0, 1'b1);
    tick(2);
    applyStimulus(src, 6'b010_101, 1'b0, 1'b0);
    tick(1);
    checkOutput("overwrite_map", 64'(bus.map_cur_o), 64'(6'b010_101));
    applyStimulus(src, 6'b010_101, 1'b0, 1'b1);
    tick(1);
    checkOutput("out_of_range_idle", 64'(bus.joy_pins_n_o), 64'h77F);

    // Both ports on source 2 mirror each other
    applyStimulus(src, 6'b010_010, 1'b1, 1'b1);
    tick(1);
    applyStimulus(src, 6'b010_010, 1'b0, 1'b0);
    tick(1);
    applyStimulus(src, 6'b010_010, 1'b0, 1'b1);
    tick(1);
    checkOutput("mirror_pins", 64'(bus.joy_pins_n_o), 64'h75D);

    // Reset while a map is pending discards it
    applyStimulus(src, 6'b000_011, 1'b1, 1'b1);
    tick(1);
    applyStimulus(src, 6'b000_011, 1'b0, 1'b1);
    reset_n = 1'b0;
    tick(1);
    checkOutput("rst_pending_cleared", 64'(bus.map_pending_o), 64'h0);
    checkOutput("rst_map_identity", 64'(bus.map_cur_o), 64'(6'b001_000));
    checkOutput("rst_pins_idle", 64'(bus.joy_pins_n_o), 64'hFFF);
    reset_n = 1'b1;
    tick(2);
    applyStimulus(src, 6'b000_011, 1'b0, 1'b0);
    tick(1);
    checkOutput("rst_no_late_commit", 64'(bus.map_cur_o), 64'(6'b001_000));
    applyStimulus(src, 6'b000_011, 1'b0, 1'b1);

    // Autofire buttons on source 0 (A and B)
    applyStimulus(64'h00C0, 6'b001_000, 1'b0, 1'b1);
    tick(2);
`ifdef MSX_JOY_AUTOFIRE_EN
    prevP6 = bus.joy_pins_n_o[PIN_P6];
    for (int c = 1; c <= 200; c++) begin
      tick(1);
      if (bus.joy_pins_n_o[PIN_P6] !== prevP6) begin
        if (lastChange >= 0) begin
          checkOutput("af_half_period", 64'(c - lastChange), 64'd50);
        end
        lastChange = c;
        changes++;
        prevP6 = bus.joy_pins_n_o[PIN_P6];
      end
    end
    checkOutput("af_toggles_seen", 64'(changes >= 3), 64'h1);
`else
    prevP6 = 1'b1;
    for (int c = 1; c <= 120; c++) begin
      tick(1);
      if (bus.joy_pins_n_o[PIN_P6] !== 1'b1 || bus.joy_pins_n_o[PIN_P9] !== 1'b1) begin
        lowCount++;
      end
    end
    checkOutput("af_disabled_p6_p9_high", 64'(lowCount), 64'd0);
    checkOutput("af_disabled_port1", 64'(bus.joy_pins_n_o[11:6]), 64'h3F);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
